// File: rtl/chroma_phase_if.sv
// Pixel-side bundle for chroma_phase_gen: timing strobes and hue/saturation in,
// phase/amplitude pair out to the sine LUT.
interface chroma_phase_if;
    logic              frame_start;
    logic              line_start;
    logic              burst_en;
    logic              active_en;
    logic [4:0]        hue;
    logic signed [5:0] saturation;
    logic [4:0]        phase;
    logic signed [5:0] amplitude;

    modport master (
        output frame_start, line_start, burst_en, active_en, hue, saturation,
        input  phase, amplitude
    );

    modport slave (
        input  frame_start, line_start, burst_en, active_en, hue, saturation,
        output phase, amplitude
    );
endinterface

// File: rtl/chroma_phase_gen.sv
// Colour-subcarrier NCO, burst insertion and PAL V-switch feeding the sine LUT
// with a registered 5-bit phase and signed 6-bit amplitude.
module chroma_phase_gen #(
    parameter int unsigned             ACC_WIDTH        = 32,
    parameter logic [ACC_WIDTH-1:0]    PHASE_INC        = ACC_WIDTH'(32'd396713489),
    parameter bit                      PAL              = 1'b1,
    parameter logic [4:0]              BURST_PHASE_NTSC = 5'd16,
    parameter logic signed [5:0]       BURST_AMPLITUDE  = 6'sd12,
    parameter int unsigned             MAX_BURST_CYCLES = 48
) (
    input  logic           clk,
    input  logic           rst_n,
    chroma_phase_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST_CYCLES + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST_CYCLES - 1);
    localparam logic signed [5:0] SAT_MIN   = 6'sb100000;
    localparam logic signed [5:0] SAT_CLAMP = 6'sb100001;
    localparam logic [4:0] PAL_BURST_V1 = 5'd20;
    localparam logic [4:0] PAL_BURST_V0 = 5'd12;

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        BURST  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    logic [ACC_WIDTH-1:0] acc;
    logic [4:0]           carrier;
    logic                 v_switch;

    state_t               state, state_nxt;
    logic                 burst_done, burst_done_nxt;
    logic [CNT_W-1:0]     burst_cnt, burst_cnt_nxt;

    logic [4:0]           phase_q, phase_nxt;
    logic signed [5:0]    amp_q, amp_nxt;

    assign carrier = acc[ACC_WIDTH-1 -: 5];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            acc <= acc + PHASE_INC;
        end
    end

    // frame_start re-phases the V-switch and wins over a coincident line_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_switch <= 1'b0;
        end else if (!PAL || bus.frame_start) begin
            v_switch <= 1'b0;
        end else if (bus.line_start) begin
            v_switch <= ~v_switch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            burst_done <= 1'b0;
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            burst_done <= burst_done_nxt;
            burst_cnt  <= burst_cnt_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the block can infer a latch.
    always_comb begin
        state_nxt      = state;
        burst_done_nxt = burst_done;
        burst_cnt_nxt  = burst_cnt;
        if (bus.line_start) begin
            state_nxt      = BLANK;
            burst_done_nxt = 1'b0;
            burst_cnt_nxt  = '0;
        end else if (state == BURST) begin
            if (bus.burst_en && (burst_cnt < BURST_LAST)) begin
                burst_cnt_nxt = burst_cnt + CNT_W'(1);
            end else begin
                state_nxt      = BLANK;
                burst_done_nxt = 1'b1;
            end
        end else if (bus.burst_en && !burst_done) begin
            state_nxt     = BURST;
            burst_cnt_nxt = '0;
        end else begin
            state_nxt = bus.active_en ? ACTIVE : BLANK;
        end
    end

    always_comb begin
        phase_nxt = carrier;
        amp_nxt   = '0;
        unique case (state_nxt)
            BURST: begin
                if (PAL) begin
                    phase_nxt = carrier + (v_switch ? PAL_BURST_V1 : PAL_BURST_V0);
                end else begin
                    phase_nxt = carrier + BURST_PHASE_NTSC;
                end
                amp_nxt = BURST_AMPLITUDE;
            end
            ACTIVE: begin
                phase_nxt = carrier + (v_switch ? (5'd0 - bus.hue) : bus.hue);
                // Symmetric LUT range: -32 has no positive counterpart.
                amp_nxt   = (bus.saturation == SAT_MIN) ? SAT_CLAMP : bus.saturation;
            end
            default: begin
                phase_nxt = carrier;
                amp_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            amp_q   <= '0;
        end else begin
            phase_q <= phase_nxt;
            amp_q   <= amp_nxt;
        end
    end

    assign bus.phase     = phase_q;
    assign bus.amplitude = amp_q;

endmodule
